if_id_skid_reg: RTL

//  Pipeline register between instruction fetch and decode in the nPower pipeline.

---
 rtl/npower_pkg.sv | 44 ++++
 rtl/if_id_skid_reg_if.sv | 36 +++
 rtl/npower_field_decode.sv | 46 ++++
 rtl/if_id_skid_reg.sv | 118 +++++++++++
 4 files changed

// File: rtl/npower_pkg.sv
// Shared types and constants for the nPower front end: beat layout between
// fetch and decode, instruction-field geometry and the skid buffer states.
package npower_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;

  // Highest instruction bit (exclusive) that any pre-decoded field reaches.
  localparam int FIELD_W = 21;

  localparam logic [OPC_W-1:0] OP_XL = 6'b010011;
  localparam logic [OPC_W-1:0] OP_DS = 6'b111110;

  // One fetched instruction together with its capture-time pre-decode.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
    logic [INSTR_W-1:0] instr;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
  } beat_t;

  // Storage slot: the beat plus its opcode, registered alongside the
  // register fields so every decode-side output comes straight from a flop.
  typedef struct packed {
    beat_t            beat;
    logic [OPC_W-1:0] opcode;
  } slot_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Sequential next pc; wraps silently at the top of the address space.
  function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch/decode handshake bundle. The buffer sits on the slave side; the
// fetch/decode environment (or a bench) drives the master side.
interface if_id_skid_reg_if;
  import npower_pkg::*;

  // Fetch side
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;

  // Decode side
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [PC_W-1:0]    out_pc_plus4;
  logic [INSTR_W-1:0] out_instr;
  logic [OPC_W-1:0]   out_opcode;
  logic [REG_W-1:0]   out_rs1;
  logic [REG_W-1:0]   out_rs2;
  logic [REG_W-1:0]   out_rd;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_pc_plus4, out_instr,
           out_opcode, out_rs1, out_rs2, out_rd
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_plus4, out_instr,
           out_opcode, out_rs1, out_rs2, out_rd
  );

endinterface

// File: rtl/npower_field_decode.sv
// Combinational register-field selection for nPower instructions. Only the
// low FIELD_W bits carry opcode and register fields, so only those come in.
module npower_field_decode
  import npower_pkg::*;
(
  input  logic [FIELD_W-1:0] instr_i,
  output logic [OPC_W-1:0]   opcode_o,
  output logic [REG_W-1:0]   rs1_o,
  output logic [REG_W-1:0]   rs2_o,
  output logic [REG_W-1:0]   rd_o
);

  logic [REG_W-1:0] field_hi;   // [20:16]
  logic [REG_W-1:0] field_mid;  // [15:11]
  logic [REG_W-1:0] field_lo;   // [10:6]

  assign opcode_o  = instr_i[OPC_W-1:0];
  assign field_hi  = instr_i[20:16];
  assign field_mid = instr_i[15:11];
  assign field_lo  = instr_i[10:6];

  // Opcode-dependent routing of the three 5-bit fields onto rs1/rs2/rd.
  always_comb begin
    rs1_o = field_mid;
    rs2_o = field_hi;
    rd_o  = field_lo;
    case (opcode_o)
      OP_XL: begin
        rs1_o = field_lo;
        rs2_o = field_mid;
        rd_o  = field_hi;
      end
      OP_DS: begin
        rs1_o = field_mid;
        rs2_o = field_lo;
        rd_o  = field_hi;
      end
      default: begin
        rs1_o = field_mid;
        rs2_o = field_hi;
        rd_o  = field_lo;
      end
    endcase
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register built as a two-entry skid buffer. The head slot
// drives decode directly; the skid slot absorbs one beat when decode stalls,
// so in_ready only depends on registered state. Flush drops every held beat
// (and any beat offered in the same cycle) by clearing valids only.
module if_id_skid_reg
  import npower_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  if_id_skid_reg_if.slave    bus
);

  skid_state_e state_q, state_d;
  slot_t       head_q, head_d;
  slot_t       skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  slot_t            in_slot;
  logic             accept;
  logic             consume;
  logic [OPC_W-1:0] dec_opcode;
  logic [REG_W-1:0] dec_rs1;
  logic [REG_W-1:0] dec_rs2;
  logic [REG_W-1:0] dec_rd;

  npower_field_decode u_decode (
    .instr_i  (bus.in_instr[FIELD_W-1:0]),
    .opcode_o (dec_opcode),
    .rs1_o    (dec_rs1),
    .rs2_o    (dec_rs2),
    .rd_o     (dec_rd)
  );

  assign accept  = bus.in_valid && in_ready_q;
  assign consume = out_valid_q && bus.out_ready;

  // Assemble the incoming beat with its pre-decode and sequential pc.
  always_comb begin
    in_slot               = '0;
    in_slot.beat.pc       = bus.in_pc;
    in_slot.beat.pc_plus4 = next_seq_pc(bus.in_pc);
    in_slot.beat.instr    = bus.in_instr;
    in_slot.beat.rs1      = dec_rs1;
    in_slot.beat.rs2      = dec_rs2;
    in_slot.beat.rd       = dec_rd;
    in_slot.opcode        = dec_opcode;
  end

  // Occupancy transitions; flush wins over any accept, data slots untouched.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = in_slot;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            head_d  = in_slot;
          end else if (accept) begin
            skid_d  = in_slot;
            state_d = ST_FULL;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the skid->head move can happen.
          if (consume) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // State, slots and handshake flags; reset clears everything including data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = head_q.beat.pc;
  assign bus.out_pc_plus4 = head_q.beat.pc_plus4;
  assign bus.out_instr    = head_q.beat.instr;
  assign bus.out_opcode   = head_q.opcode;
  assign bus.out_rs1      = head_q.beat.rs1;
  assign bus.out_rs2      = head_q.beat.rs2;
  assign bus.out_rd       = head_q.beat.rd;

endmodule
